// File: rtl/uart_dev.sv
// uart_dev: memory-mapped 8N1 UART responder behind the system bridge.
//   clk, reset      : system clock, synchronous active-high reset
//   Addr[31:2]      : word address, only Addr[3:2] decoded (DATA/STATUS/CTRL/DIV)
//   WE, Din         : one-cycle write strobe and write data
//   Dout            : combinational read data
//   IRQ             : registered level interrupt, ien & rx_valid
//   uart_rxd        : asynchronous serial input, idle high
//   uart_txd        : registered serial output, idle high
//
// TX states
//   state    | meaning
//   TX_IDLE  | line high, accepts a DATA write
//   TX_START | driving start bit (0) for DIV cycles
//   TX_DATA  | driving 8 data bits, LSB first
//   TX_STOP  | driving stop bit (1) for DIV cycles
// RX states
//   state    | meaning
//   RX_IDLE  | waiting for a 1->0 edge on the synchronised line
//   RX_START | waiting DIV/2 to confirm the start bit
//   RX_DATA  | taking 8 samples spaced DIV apart
//   RX_STOP  | taking the stop-bit sample
//   RX_WAIT  | framing error seen, waiting for the line to return high
module uart_dev #(
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter logic [15:0] MIN_DIV     = 16'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic [15:0] div_reg;
    logic        ien, rx_valid, overrun, frame_err;
    logic [7:0]  rx_data;

    logic wr_data, wr_status, wr_ctrl, wr_div;
    assign wr_data   = WE && (Addr[3:2] == 2'd0);
    assign wr_status = WE && (Addr[3:2] == 2'd1);
    assign wr_ctrl   = WE && (Addr[3:2] == 2'd2);
    assign wr_div    = WE && (Addr[3:2] == 2'd3);

    logic unused_bits;
    assign unused_bits = ^{Addr[31:4], Din[31:16]};

    // ---------------- TX engine ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_busy, txd_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_txd <= txd_n;
        end
    end

    // Bit timer is a down-counter reloaded with DIV-1; terminal count 0 ends the bit.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        case (tx_state)
            TX_IDLE: if (wr_data) begin
                tx_state_n = TX_START;
                tx_shift_n = Din[7:0];
                tx_div_n   = div_reg;
                tx_cnt_n   = div_reg - 16'd1;
            end
            TX_START: if (tx_cnt == 16'd0) begin
                tx_state_n = TX_DATA;
                tx_bit_n   = 3'd0;
                tx_cnt_n   = tx_div - 16'd1;
            end else begin
                tx_cnt_n = tx_cnt - 16'd1;
            end
            TX_DATA: if (tx_cnt == 16'd0) begin
                tx_cnt_n = tx_div - 16'd1;
                if (tx_bit == 3'd7) begin
                    tx_state_n = TX_STOP;
                end else begin
                    tx_bit_n   = tx_bit + 3'd1;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                end
            end else begin
                tx_cnt_n = tx_cnt - 16'd1;
            end
            TX_STOP: if (tx_cnt == 16'd0) begin
                tx_state_n = TX_IDLE;
            end else begin
                tx_cnt_n = tx_cnt - 16'd1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // txd is registered from the next state so the line moves on the same edge as the FSM.
    always_comb begin
        tx_busy = (tx_state != TX_IDLE);
        case (tx_state_n)
            TX_START: txd_n = 1'b0;
            TX_DATA:  txd_n = tx_shift_n[0];
            default:  txd_n = 1'b1;
        endcase
    end

    // ---------------- RX engine ----------------
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_done_ok, rx_done_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= uart_rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        case (rx_state)
            RX_IDLE: if (rx_prev && !rx_s2) begin
                rx_state_n = RX_START;
                rx_div_n   = div_reg;
                rx_cnt_n   = {1'b0, div_reg[15:1]} - 16'd1;
            end
            RX_START: if (rx_cnt == 16'd0) begin
                if (rx_s2) begin
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_state_n = RX_DATA;
                    rx_bit_n   = 3'd0;
                    rx_cnt_n   = rx_div - 16'd1;
                end
            end else begin
                rx_cnt_n = rx_cnt - 16'd1;
            end
            RX_DATA: if (rx_cnt == 16'd0) begin
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_cnt_n   = rx_div - 16'd1;
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                else                rx_bit_n   = rx_bit + 3'd1;
            end else begin
                rx_cnt_n = rx_cnt - 16'd1;
            end
            RX_STOP: if (rx_cnt == 16'd0) begin
                rx_state_n = rx_s2 ? RX_IDLE : RX_WAIT;
            end else begin
                rx_cnt_n = rx_cnt - 16'd1;
            end
            RX_WAIT: if (rx_s2) rx_state_n = RX_IDLE;
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_done_ok  = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && rx_s2;
        rx_done_err = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && !rx_s2;
    end

    // ---------------- registers and flags ----------------
    // A flag being set wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg   <= DEFAULT_DIV;
            ien       <= 1'b0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= '0;
            IRQ       <= 1'b0;
        end else begin
            if (wr_div)  div_reg <= (Din[15:0] < MIN_DIV) ? MIN_DIV : Din[15:0];
            if (wr_ctrl) ien     <= Din[0];
            if (rx_done_ok) rx_data <= rx_shift;
            rx_valid  <= rx_done_ok | (rx_valid & ~(wr_status & Din[1]));
            overrun   <= (rx_done_ok & rx_valid) | (overrun & ~(wr_status & Din[2]));
            frame_err <= rx_done_err | (frame_err & ~(wr_status & Din[3]));
            IRQ       <= ien & rx_valid;
        end
    end

    always_comb begin
        case (Addr[3:2])
            2'd0:    Dout = {24'b0, rx_data};
            2'd1:    Dout = {28'b0, frame_err, overrun, rx_valid, tx_busy};
            2'd2:    Dout = {31'b0, ien};
            default: Dout = {16'b0, div_reg};
        endcase
    end

endmodule

// File: tb/tb_uart_dev.sv
module tb_uart_dev;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        uart_rxd;
    logic        uart_txd;
    logic        loopback = 1'b0;
    logic        rxd_drv = 1'b1;

    int n_pass = 0;
    int n_total = 0;

    assign uart_rxd = loopback ? uart_txd : rxd_drv;

    always #10 clk = ~clk;

    uart_dev dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout),
        .IRQ(IRQ), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'b0, a};
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'b0, a};
        #1;
        d = Dout;
    endtask

    task automatic wait_tx_idle(input int bound);
        logic [31:0] s;
        int i;
        for (i = 0; i < bound; i++) begin
            reg_read(2'd1, s);
            if (s[0] == 1'b0) break;
            tick();
        end
        if (i == bound) begin
            n_total++;
            $display("FAIL tx_idle_timeout: tx_busy still 1 after %0d cycles, required 0", bound);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        reg_read(2'd0, r);
        n_total++; if (r !== 32'h0) $display("FAIL reset_data: got %h expected %h", r, 32'h0); else n_pass++;
        reg_read(2'd1, r);
        n_total++; if (r !== 32'h0) $display("FAIL reset_status: got %h expected %h", r, 32'h0); else n_pass++;
        reg_read(2'd2, r);
        n_total++; if (r !== 32'h0) $display("FAIL reset_ctrl: got %h expected %h", r, 32'h0); else n_pass++;
        reg_read(2'd3, r);
        n_total++; if (r !== 32'd434) $display("FAIL reset_div: got %0d expected 434", r); else n_pass++;
        n_total++; if (uart_txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", uart_txd); else n_pass++;
        n_total++; if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b expected 0", IRQ); else n_pass++;
    endtask

    task automatic test_div_clamp();
        logic [31:0] r;
        reg_write(2'd3, 32'd2);
        reg_read(2'd3, r);
        n_total++; if (r !== 32'd4) $display("FAIL div_clamp: got %0d expected 4", r); else n_pass++;
        reg_write(2'd3, 32'h0001_0007);
        reg_read(2'd3, r);
        n_total++; if (r !== 32'd7) $display("FAIL div_upper_bits: got %0d expected 7", r); else n_pass++;
        reg_write(2'd3, 32'd4);
    endtask

    task automatic test_tx();
        logic [31:0] s;
        logic [9:0]  fr;
        int errs;
        fr = {1'b1, 8'hA5, 1'b0};
        errs = 0;
        reg_write(2'd0, 32'h0000_00A5);
        for (int k = 0; k < 40; k++) begin
            reg_read(2'd1, s);
            if (uart_txd !== fr[k/4] || s[0] !== 1'b1) begin
                errs++;
                $display("FAIL tx_a5_cycle%0d: txd=%b busy=%b expected txd=%b busy=1", k, uart_txd, s[0], fr[k/4]);
            end
            if (k == 9) begin
                Addr = 30'd0; Din = 32'h0000_00FF; WE = 1'b1;
                tick();
                WE = 1'b0;
            end else begin
                tick();
            end
        end
        n_total++; if (errs != 0) $display("FAIL tx_a5_frame: %0d bad cycles, expected 0", errs); else n_pass++;
        reg_read(2'd1, s);
        n_total++; if (s[0] !== 1'b0) $display("FAIL tx_busy_end: got %b expected 0 after 40 cycles", s[0]); else n_pass++;
        n_total++; if (uart_txd !== 1'b1) $display("FAIL tx_idle_line: got %b expected 1", uart_txd); else n_pass++;
        repeat (8) tick();
        n_total++; if (uart_txd !== 1'b1) $display("FAIL tx_no_queue: got %b expected 1 (second write must be dropped)", uart_txd); else n_pass++;
    endtask

    task automatic test_loopback_irq();
        logic [31:0] s, r;
        int i;
        loopback = 1'b1;
        reg_write(2'd2, 32'h1);
        reg_write(2'd0, 32'h0000_003C);
        for (i = 0; i < 80; i++) begin
            reg_read(2'd1, s);
            if (s[1]) break;
            tick();
        end
        n_total++; if (s[1] !== 1'b1) $display("FAIL lb_rx_valid: got %b expected 1 within 80 cycles", s[1]); else n_pass++;
        n_total++; if (IRQ !== 1'b0) $display("FAIL lb_irq_delay: got %b expected 0 in the rx_valid cycle", IRQ); else n_pass++;
        reg_read(2'd0, r);
        n_total++; if (r !== 32'h3C) $display("FAIL lb_rx_data: got %h expected 3c", r); else n_pass++;
        tick();
        n_total++; if (IRQ !== 1'b1) $display("FAIL lb_irq_rise: got %b expected 1", IRQ); else n_pass++;
        reg_write(2'd1, 32'h2);
        reg_read(2'd1, s);
        n_total++; if (s[1] !== 1'b0) $display("FAIL lb_w1c_valid: got %b expected 0", s[1]); else n_pass++;
        n_total++; if (IRQ !== 1'b1) $display("FAIL lb_irq_hold: got %b expected 1", IRQ); else n_pass++;
        tick();
        n_total++; if (IRQ !== 1'b0) $display("FAIL lb_irq_fall: got %b expected 0", IRQ); else n_pass++;
        wait_tx_idle(60);
        repeat (4) tick();
    endtask

    task automatic test_overrun();
        logic [31:0] s, r;
        reg_write(2'd0, 32'h11);
        wait_tx_idle(60);
        reg_write(2'd0, 32'h22);
        wait_tx_idle(60);
        repeat (4) tick();
        reg_read(2'd0, r);
        n_total++; if (r !== 32'h22) $display("FAIL ovr_data: got %h expected 22", r); else n_pass++;
        reg_read(2'd1, s);
        n_total++; if (s !== 32'h6) $display("FAIL ovr_status: got %h expected 6", s); else n_pass++;
        reg_write(2'd1, 32'h4);
        reg_read(2'd1, s);
        n_total++; if (s !== 32'h2) $display("FAIL ovr_w1c: got %h expected 2", s); else n_pass++;
        reg_write(2'd1, 32'h3);
        reg_read(2'd1, s);
        n_total++; if (s !== 32'h0) $display("FAIL ovr_clear_all: got %h expected 0", s); else n_pass++;
        loopback = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_glitch_frame_err();
        logic [31:0] s, r;
        logic [9:0]  fr;
        rxd_drv = 1'b1;
        reg_write(2'd3, 32'd8);
        repeat (4) tick();
        rxd_drv = 1'b0;
        tick();
        rxd_drv = 1'b1;
        repeat (20) tick();
        reg_read(2'd1, s);
        n_total++; if (s !== 32'h0) $display("FAIL glitch_status: got %h expected 0", s); else n_pass++;
        reg_read(2'd0, r);
        n_total++; if (r !== 32'h22) $display("FAIL glitch_data: got %h expected 22", r); else n_pass++;
        fr = {1'b0, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd_drv = fr[b];
            repeat (8) tick();
        end
        repeat (8) tick();
        rxd_drv = 1'b1;
        repeat (6) tick();
        reg_read(2'd1, s);
        n_total++; if (s !== 32'h8) $display("FAIL ferr_status: got %h expected 8", s); else n_pass++;
        reg_read(2'd0, r);
        n_total++; if (r !== 32'h22) $display("FAIL ferr_data: got %h expected 22", r); else n_pass++;
        reg_write(2'd1, 32'h8);
        reg_read(2'd1, s);
        n_total++; if (s !== 32'h0) $display("FAIL ferr_w1c: got %h expected 0", s); else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] s;
        logic [9:0]  fr;
        int errs;
        reg_write(2'd3, 32'd4);
        reg_write(2'd0, 32'h00);
        repeat (17) tick();
        n_total++; if (uart_txd !== 1'b0) $display("FAIL rst_pre_txd: got %b expected 0 in bit 3", uart_txd); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        reg_read(2'd1, s);
        n_total++; if (uart_txd !== 1'b1 || s[0] !== 1'b0)
            $display("FAIL rst_mid_frame: txd=%b busy=%b expected txd=1 busy=0", uart_txd, s[0]);
        else n_pass++;
        reg_read(2'd3, s);
        n_total++; if (s !== 32'd434) $display("FAIL rst_div: got %0d expected 434", s); else n_pass++;
        reg_write(2'd3, 32'd4);
        fr = {1'b1, 8'h5A, 1'b0};
        errs = 0;
        reg_write(2'd0, 32'h5A);
        for (int k = 0; k < 40; k++) begin
            reg_read(2'd1, s);
            if (uart_txd !== fr[k/4] || s[0] !== 1'b1) begin
                errs++;
                $display("FAIL tx_5a_cycle%0d: txd=%b busy=%b expected txd=%b busy=1", k, uart_txd, s[0], fr[k/4]);
            end
            tick();
        end
        n_total++; if (errs != 0) $display("FAIL tx_5a_frame: %0d bad cycles, expected 0", errs); else n_pass++;
        reg_read(2'd1, s);
        n_total++; if (s[0] !== 1'b0) $display("FAIL tx_5a_end: busy=%b expected 0", s[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_div_clamp();
        test_tx();
        test_loopback_irq();
        test_overrun();
        test_glitch_frame_err();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
